// File: rtl/ddr_dmaster_p2b_encoder.sv
// ddr_dmaster_p2b_encoder
// Transmit-side packets-to-bytes encoder for the DDR debug-master byte link.
// Each accepted beat is held and expanded into SOP / channel marker / EOP /
// data bytes. Payload and channel bytes that collide with the reserved
// characters 0x7A..0x7D are escaped as ESC followed by (byte ^ 0x20).
//
// Build option: DDR_P2B_CHANNEL_EN
//   defined   - channel tracking; a CHAN marker plus the channel byte are sent
//               whenever the channel differs from the last one sent.
//   undefined - in_channel is ignored and the stream is implicitly channel 0.
//
// state    | meaning
// ---------+---------------------------------------------
// IDLE     | nothing held, waiting for a beat
// S_SOP    | driving SOP (0x7A)
// S_CHMK   | driving CHAN marker (0x7C)
// S_CHESC  | driving ESC ahead of an escaped channel byte
// S_CHBYTE | driving the channel byte (escaped if needed)
// S_EOP    | driving EOP (0x7B)
// S_DESC   | driving ESC ahead of an escaped data byte
// S_DATA   | driving the data byte; the next beat may be accepted here

module ddr_dmaster_p2b_encoder #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic [CHANNEL_WIDTH-1:0] in_channel,
    input  logic                     in_startofpacket,
    input  logic                     in_endofpacket,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data
);

    localparam logic [7:0] SOP_CHAR  = 8'h7A;
    localparam logic [7:0] EOP_CHAR  = 8'h7B;
    localparam logic [7:0] CHAN_CHAR = 8'h7C;
    localparam logic [7:0] ESC_CHAR  = 8'h7D;
    localparam logic [7:0] ESC_XOR   = 8'h20;

    typedef enum logic [3:0] {
        IDLE,
        S_SOP,
        S_CHMK,
        S_CHESC,
        S_CHBYTE,
        S_EOP,
        S_DESC,
        S_DATA
    } state_e;

    state_e     state_q, state_d;
    logic       out_valid_q;
    logic [7:0] out_data_q, out_data_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_sop_q, hold_sop_d;
    logic       hold_eop_q, hold_eop_d;
    logic       hold_chg_q, hold_chg_d;
    logic [7:0] ch_byte_q, ch_byte_d;
    logic       chg_in;
    logic       accept;
    logic       advance;

    function automatic logic is_special(input logic [7:0] b);
        return (b >= SOP_CHAR) && (b <= ESC_CHAR);
    endfunction

    function automatic state_e data_state(input logic [7:0] d);
        return is_special(d) ? S_DESC : S_DATA;
    endfunction

    function automatic state_e first_state(input logic sop, input logic chg,
                                           input logic eop, input logic [7:0] d);
        if (sop)      return S_SOP;
        else if (chg) return S_CHMK;
        else if (eop) return S_EOP;
        else          return data_state(d);
    endfunction

    // Byte driven in a given state; depends only on state and held beat.
    function automatic logic [7:0] byte_of(input state_e st, input logic [7:0] d,
                                           input logic [7:0] ch);
        case (st)
            S_SOP:    return SOP_CHAR;
            S_CHMK:   return CHAN_CHAR;
            S_CHESC:  return ESC_CHAR;
            S_CHBYTE: return is_special(ch) ? (ch ^ ESC_XOR) : ch;
            S_EOP:    return EOP_CHAR;
            S_DESC:   return ESC_CHAR;
            S_DATA:   return is_special(d) ? (d ^ ESC_XOR) : d;
            default:  return 8'h00;
        endcase
    endfunction

    assign in_ready  = reset_n && ((state_q == IDLE) || ((state_q == S_DATA) && out_ready));
    assign accept    = in_ready && in_valid;
    assign advance   = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef DDR_P2B_CHANNEL_EN
    logic [7:0] in_ch_byte;
    logic [7:0] last_ch_q;
    logic       last_vld_q;

    // Zero-extend the incoming channel to a link byte.
    always_comb begin
        in_ch_byte = 8'h00;
        in_ch_byte[CHANNEL_WIDTH-1:0] = in_channel;
    end

    assign chg_in    = !last_vld_q || (in_ch_byte != last_ch_q);
    assign ch_byte_d = accept ? in_ch_byte : ch_byte_q;

    // Held channel byte and last-channel-sent tracking (updated when the channel byte leaves).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_byte_q  <= 8'h00;
            last_ch_q  <= 8'h00;
            last_vld_q <= 1'b0;
        end else begin
            ch_byte_q <= ch_byte_d;
            if ((state_q == S_CHBYTE) && advance) begin
                last_ch_q  <= ch_byte_q;
                last_vld_q <= 1'b1;
            end
        end
    end
`else
    logic unused_channel;

    assign chg_in         = 1'b0;
    assign ch_byte_d      = 8'h00;
    assign ch_byte_q      = 8'h00;
    assign unused_channel = ^in_channel;
`endif

    // Next-state, holding-register capture and next output byte.
    always_comb begin
        hold_data_d = hold_data_q;
        hold_sop_d  = hold_sop_q;
        hold_eop_d  = hold_eop_q;
        hold_chg_d  = hold_chg_q;
        if (accept) begin
            hold_data_d = in_data;
            hold_sop_d  = in_startofpacket;
            hold_eop_d  = in_endofpacket;
            hold_chg_d  = chg_in;
        end

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = first_state(in_startofpacket, chg_in, in_endofpacket, in_data);
            end
            S_SOP: begin
                if (advance) begin
                    if (hold_chg_q)      state_d = S_CHMK;
                    else if (hold_eop_q) state_d = S_EOP;
                    else                 state_d = data_state(hold_data_q);
                end
            end
            S_CHMK: begin
                if (advance) state_d = is_special(ch_byte_q) ? S_CHESC : S_CHBYTE;
            end
            S_CHESC: begin
                if (advance) state_d = S_CHBYTE;
            end
            S_CHBYTE: begin
                if (advance) state_d = hold_eop_q ? S_EOP : data_state(hold_data_q);
            end
            S_EOP: begin
                if (advance) state_d = data_state(hold_data_q);
            end
            S_DESC: begin
                if (advance) state_d = S_DATA;
            end
            S_DATA: begin
                if (advance) begin
                    if (accept) state_d = first_state(in_startofpacket, chg_in, in_endofpacket, in_data);
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        out_data_d = byte_of(state_d, hold_data_d, ch_byte_d);
    end

    // Encoder FSM with registered out_valid / out_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            hold_data_q <= 8'h00;
            hold_sop_q  <= 1'b0;
            hold_eop_q  <= 1'b0;
            hold_chg_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d != IDLE);
            out_data_q  <= out_data_d;
            hold_data_q <= hold_data_d;
            hold_sop_q  <= hold_sop_d;
            hold_eop_q  <= hold_eop_d;
            hold_chg_q  <= hold_chg_d;
        end
    end

endmodule

// File: tb/tb_ddr_dmaster_p2b_encoder.sv
// Bench for ddr_dmaster_p2b_encoder: directed scenarios plus randomized
// traffic, checked against a byte-queue reference model of the encoding rules.
module tb_ddr_dmaster_p2b_encoder;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_ready;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic [CW-1:0] in_channel = '0;
    logic          in_startofpacket = 1'b0;
    logic          in_endofpacket = 1'b0;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic [7:0]    out_data;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    logic [7:0] m_last = 8'h00;
    logic       m_last_vld = 1'b0;

    ddr_dmaster_p2b_encoder #(.CHANNEL_WIDTH(CW)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_ready         (in_ready),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_channel       (in_channel),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_esc(input logic [7:0] b);
        if (b >= 8'h7A && b <= 8'h7D) begin
            exp_q.push_back(8'h7D);
            exp_q.push_back(b ^ 8'h20);
        end else begin
            exp_q.push_back(b);
        end
    endtask

    // Reference: list of bytes one accepted beat must produce.
    task automatic model_accept(input logic [7:0] d, input logic [7:0] ch,
                                input logic sop, input logic eop);
        if (sop) exp_q.push_back(8'h7A);
`ifdef DDR_P2B_CHANNEL_EN
        if (!m_last_vld || ch != m_last) begin
            exp_q.push_back(8'h7C);
            push_esc(ch);
            m_last     = ch;
            m_last_vld = 1'b1;
        end
`endif
        if (eop) exp_q.push_back(8'h7B);
        push_esc(d);
    endtask

    // Monitor: sample between edges, compare against the model queue.
    always @(negedge clk) begin
        logic       exp_rdy;
        logic [7:0] ch8;
        if (!reset_n) begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_out_data", {24'd0, out_data}, 32'd0);
        end else begin
            exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            if (out_valid && exp_q.size() != 0)
                chk("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
            if (out_valid && out_ready && exp_q.size() != 0) begin
                log_q.push_back(out_data);
                void'(exp_q.pop_front());
            end
            if (in_valid && exp_rdy) begin
                ch8 = 8'h00;
                ch8[CW-1:0] = in_channel;
                model_accept(in_data, ch8, in_startofpacket, in_endofpacket);
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic [7:0] ch,
                             input logic sop, input logic eop);
        bit done = 0;
        in_valid = 1'b1; in_data = d; in_channel = ch[CW-1:0];
        in_startofpacket = sop; in_endofpacket = eop;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!out_valid && exp_q.size() == 0) done = 1;
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_log(input string tag, input logic [7:0] e[$]);
        chk({tag, "_len"}, log_q.size(), e.size());
        for (int i = 0; i < e.size() && i < log_q.size(); i++)
            chk(tag, {24'd0, log_q[i]}, {24'd0, e[i]});
        log_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        m_last_vld = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] e[$];
        bit found;
        logic [7:0] chs[4];
        chs[0] = 8'h00; chs[1] = 8'h01; chs[2] = 8'h7C; chs[3] = 8'h7A;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        log_q.delete();

        // first beat after reset
        send_beat(8'h41, 8'h00, 1'b1, 1'b1);
        wait_idle();
`ifdef DDR_P2B_CHANNEL_EN
        e = {8'h7A, 8'h7C, 8'h00, 8'h7B, 8'h41};
`else
        e = {8'h7A, 8'h7B, 8'h41};
`endif
        check_log("first_beat", e);

        // escaped payload on same channel
        send_beat(8'h7B, 8'h00, 1'b0, 1'b0);
        wait_idle();
        e = {8'h7D, 8'h5B};
        check_log("esc_7b", e);
        send_beat(8'h7D, 8'h00, 1'b0, 1'b0);
        wait_idle();
        e = {8'h7D, 8'h5D};
        check_log("esc_7d", e);

        // channel change to a reserved value
        send_beat(8'h10, 8'h7C, 1'b1, 1'b0);
        wait_idle();
`ifdef DDR_P2B_CHANNEL_EN
        e = {8'h7A, 8'h7C, 8'h7D, 8'h5C, 8'h10};
`else
        e = {8'h7A, 8'h10};
`endif
        check_log("chan_esc", e);

        // backpressure on the channel byte (data byte without channels)
        send_beat(8'h33, 8'h05, 1'b1, 1'b0);
`ifdef DDR_P2B_CHANNEL_EN
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_data", {24'd0, out_data}, 32'h05);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
        end
        e = {8'h7A, 8'h7C, 8'h05, 8'h33};
`else
        repeat (1) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_data", {24'd0, out_data}, 32'h33);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
        end
        e = {8'h7A, 8'h33};
`endif
        @(posedge clk); #1 out_ready = 1'b1;
        wait_idle();
        check_log("backpressure", e);

        // back-to-back unmarked beats
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_data = 8'(k); in_channel = 8'h05;
            @(negedge clk);
            chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle();
        e = {8'h01, 8'h02, 8'h03, 8'h04};
        check_log("b2b", e);

        // reset while EOP is on the link
        send_beat(8'h41, 8'h00, 1'b1, 1'b1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid && out_data == 8'h7B) found = 1;
            else begin @(posedge clk); #1; end
        end
        chk("eop_seen", {31'd0, found}, 32'd1);
        do_reset();
        log_q.delete();
        send_beat(8'h22, 8'h00, 1'b0, 1'b0);
        wait_idle();
`ifdef DDR_P2B_CHANNEL_EN
        e = {8'h7C, 8'h00, 8'h22};
`else
        e = {8'h22};
`endif
        check_log("after_reset", e);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid         = ($urandom_range(0, 3) != 0);
            out_ready        = ($urandom_range(0, 3) != 0);
            in_data          = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(8'h7A, 8'h7D))
                                                           : 8'($urandom);
            in_channel       = chs[$urandom_range(0, 3)][CW-1:0];
            in_startofpacket = $urandom_range(0, 1) == 1;
            in_endofpacket   = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 299) == 0) do_reset();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
